// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bus between the multicycle FSM and the MIPS32 datapath

interface multicycle_control_if;
   // inputs to the controller
   logic [5:0] op;
   logic       mem_ready;
   // datapath enables and selects
   logic       pc_write;
   logic       pc_write_cond;
   logic       pc_write_ne;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       zero_ext;
   logic [2:0] alu_op;
   logic [1:0] pc_source;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  op, mem_ready,
      output pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             zero_ext, alu_op, pc_source, instr_done, illegal
   );

   modport slave (
      output op, mem_ready,
      input  pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             zero_ext, alu_op, pc_source, instr_done, illegal
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS32 main control FSM with registered control outputs

module multicycle_control #(
   parameter logic [1:0] RA_SEL = 2'b10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   multicycle_control_if.master  bus
);

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_REXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_TRAP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   // Registered Moore controls. The two flags at the end mark the states whose
   // outputs also depend on mem_ready in the current cycle.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_write_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       zero_ext;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal;
      logic       in_fetch;
      logic       in_memwr;
   } ctrl_t;

   state_t     state_q, state_d;
   ctrl_t      ctrl_q, ctrl_d;
   logic [2:0] imm_alu_op;
   logic       imm_zext;

   // ALU function and immediate extension for the I-type arithmetic group
   always_comb begin
      imm_alu_op = ALU_ADD;
      imm_zext   = 1'b0;
      case (bus.op)
         OP_ANDI: begin
            imm_alu_op = ALU_AND;
            imm_zext   = 1'b1;
         end
         OP_ORI: begin
            imm_alu_op = ALU_OR;
            imm_zext   = 1'b1;
         end
         OP_SLTI: imm_alu_op = ALU_SLT;
         default: imm_alu_op = ALU_ADD;
      endcase
   end

   // Next-state logic: memory phases hold until mem_ready, DECODE dispatches on op
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:    state_d = S_FETCH;
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW:                      state_d = S_MEMADR;
               OP_RTYPE:                          state_d = S_REXEC;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
               OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
               OP_J:                              state_d = S_JUMP;
               OP_JAL:                            state_d = S_JAL;
               default:                           state_d = S_TRAP;
            endcase
         end
         S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
         S_REXEC:  state_d = S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_IEXEC:  state_d = S_IWB;
         S_IWB:    state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_JAL:    state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_RST;
      endcase
   end

   // Controls for the state being entered, so they appear as flop outputs
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         S_FETCH: begin
            ctrl_d.mem_read  = 1'b1;
            ctrl_d.alu_src_b = 2'b01;
            ctrl_d.alu_op    = ALU_ADD;
            ctrl_d.in_fetch  = 1'b1;
         end
         S_DECODE: begin
            // branch target precomputed while the opcode is decoded
            ctrl_d.alu_src_b = 2'b11;
            ctrl_d.alu_op    = ALU_ADD;
         end
         S_MEMADR: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
            ctrl_d.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            ctrl_d.mem_read = 1'b1;
            ctrl_d.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_to_reg = 2'b01;
            ctrl_d.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.iord      = 1'b1;
            ctrl_d.in_memwr  = 1'b1;
         end
         S_REXEC: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.reg_dst    = 2'b01;
            ctrl_d.instr_done = 1'b1;
         end
         S_IEXEC: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
            ctrl_d.alu_op    = imm_alu_op;
            ctrl_d.zero_ext  = imm_zext;
         end
         S_IWB: begin
            // ALU settings held so ALUOut stays consistent during writeback
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.alu_op     = imm_alu_op;
            ctrl_d.zero_ext   = imm_zext;
            ctrl_d.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl_d.alu_src_a     = 1'b1;
            ctrl_d.alu_op        = ALU_SUB;
            ctrl_d.pc_source     = 2'b01;
            ctrl_d.pc_write_cond = (bus.op == OP_BEQ);
            ctrl_d.pc_write_ne   = (bus.op == OP_BNE);
            ctrl_d.instr_done    = 1'b1;
         end
         S_JUMP: begin
            ctrl_d.pc_write   = 1'b1;
            ctrl_d.pc_source  = 2'b10;
            ctrl_d.instr_done = 1'b1;
         end
         S_JAL: begin
            // PC already holds PC+4 here, which is the link value
            ctrl_d.pc_write   = 1'b1;
            ctrl_d.pc_source  = 2'b10;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.reg_dst    = RA_SEL;
            ctrl_d.mem_to_reg = 2'b10;
            ctrl_d.instr_done = 1'b1;
         end
         S_TRAP: ctrl_d.illegal = 1'b1;
         default: ctrl_d = '0;
      endcase
   end

   // State and control registers; reset clears everything at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_RST;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Handshake-qualified enables combine the registered state flag with mem_ready
   assign bus.ir_write      = ctrl_q.in_fetch & bus.mem_ready;
   assign bus.pc_write      = ctrl_q.pc_write | (ctrl_q.in_fetch & bus.mem_ready);
   assign bus.instr_done    = ctrl_q.instr_done | (ctrl_q.in_memwr & bus.mem_ready);
   assign bus.pc_write_cond = ctrl_q.pc_write_cond;
   assign bus.pc_write_ne   = ctrl_q.pc_write_ne;
   assign bus.iord          = ctrl_q.iord;
   assign bus.mem_read      = ctrl_q.mem_read;
   assign bus.mem_write     = ctrl_q.mem_write;
   assign bus.reg_dst       = ctrl_q.reg_dst;
   assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
   assign bus.reg_write     = ctrl_q.reg_write;
   assign bus.alu_src_a     = ctrl_q.alu_src_a;
   assign bus.alu_src_b     = ctrl_q.alu_src_b;
   assign bus.zero_ext      = ctrl_q.zero_ext;
   assign bus.alu_op        = ctrl_q.alu_op;
   assign bus.pc_source     = ctrl_q.pc_source;
   assign bus.illegal       = ctrl_q.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed cycle-by-cycle checks of the multicycle control FSM

module tb_multicycle_control;
   logic clk;
   logic reset_n;
   int   pass_cnt;
   int   total_cnt;

   multicycle_control_if bus_if ();

   multicycle_control dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pcw, pcwc, pcwn, iord, mr, mw, irw, rd[2], mtr[2], rw, asa, asb[2], ze, aop[3], ps[2], done, ill}
   logic [22:0] outs;
   assign outs = {bus_if.pc_write, bus_if.pc_write_cond, bus_if.pc_write_ne, bus_if.iord,
                  bus_if.mem_read, bus_if.mem_write, bus_if.ir_write, bus_if.reg_dst,
                  bus_if.mem_to_reg, bus_if.reg_write, bus_if.alu_src_a, bus_if.alu_src_b,
                  bus_if.zero_ext, bus_if.alu_op, bus_if.pc_source, bus_if.instr_done,
                  bus_if.illegal};

   localparam logic [22:0] E_ZERO   = 23'd0;
   localparam logic [22:0] E_FR     = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,2'b01,1'b0,3'b000,2'b00,1'b0,1'b0};
   localparam logic [22:0] E_FW     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b01,1'b0,3'b000,2'b00,1'b0,1'b0};
   localparam logic [22:0] E_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b11,1'b0,3'b000,2'b00,1'b0,1'b0};
   localparam logic [22:0] E_REXEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,1'b0,3'b010,2'b00,1'b0,1'b0};
   localparam logic [22:0] E_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b1,1'b0,2'b00,1'b0,3'b000,2'b00,1'b1,1'b0};
   localparam logic [22:0] E_MADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,1'b0,3'b000,2'b00,1'b0,1'b0};
   localparam logic [22:0] E_MRD    = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,1'b0,1'b0};
   localparam logic [22:0] E_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b1,1'b0,2'b00,1'b0,3'b000,2'b00,1'b1,1'b0};
   localparam logic [22:0] E_MWR_W  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,1'b0,1'b0};
   localparam logic [22:0] E_MWR_R  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,1'b1,1'b0};
   localparam logic [22:0] E_BEQ    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,1'b0,3'b001,2'b01,1'b1,1'b0};
   localparam logic [22:0] E_BNE    = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,1'b0,3'b001,2'b01,1'b1,1'b0};
   localparam logic [22:0] E_JAL    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b10,1'b1,1'b0,2'b00,1'b0,3'b000,2'b10,1'b1,1'b0};
   localparam logic [22:0] E_IEX_OR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,1'b1,3'b100,2'b00,1'b0,1'b0};
   localparam logic [22:0] E_IWB_OR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,2'b00,1'b1,3'b100,2'b00,1'b1,1'b0};
   localparam logic [22:0] E_TRAP   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,1'b0,1'b1};

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      bus_if.op = 6'h00;
      bus_if.mem_ready = 1'b1;
      reset_n = 1'b0;
      step();
      step();
      #1;
      total_cnt++;
      if (outs !== E_ZERO) $display("FAIL reset_held: got %h want %h", outs, E_ZERO);
      else pass_cnt++;
      reset_n = 1'b1;
      #1;
      total_cnt++;
      if (outs !== E_ZERO) $display("FAIL reset_rst_state: got %h want %h", outs, E_ZERO);
      else pass_cnt++;
      step();
      #1;
      total_cnt++;
      if (outs !== E_FR) $display("FAIL reset_first_fetch: got %h want %h", outs, E_FR);
      else pass_cnt++;
   endtask

   task automatic test_rtype();
      logic [22:0] ev [0:4];
      ev = '{E_FR, E_DEC, E_REXEC, E_RWB, E_FR};
      bus_if.op = 6'h00;
      bus_if.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total_cnt++;
         if (outs !== ev[i]) $display("FAIL rtype cyc%0d: got %h want %h", i, outs, ev[i]);
         else pass_cnt++;
         if (i < 4) step();
      end
   endtask

   task automatic test_lw_waits();
      logic [22:0] ev [0:10];
      logic        mv [0:10];
      ev = '{E_FW, E_FW, E_FR, E_DEC, E_MADR, E_MRD, E_MRD, E_MRD, E_MRD, E_MWB, E_FR};
      mv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      bus_if.op = 6'h23;
      for (int i = 0; i < 11; i++) begin
         bus_if.mem_ready = mv[i];
         #1;
         total_cnt++;
         if (outs !== ev[i]) $display("FAIL lw_waits cyc%0d: got %h want %h", i, outs, ev[i]);
         else pass_cnt++;
         if (i < 10) step();
      end
   endtask

   task automatic test_sw_wait();
      logic [22:0] ev [0:5];
      logic        mv [0:5];
      ev = '{E_FR, E_DEC, E_MADR, E_MWR_W, E_MWR_R, E_FR};
      mv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      bus_if.op = 6'h2B;
      for (int i = 0; i < 6; i++) begin
         bus_if.mem_ready = mv[i];
         #1;
         total_cnt++;
         if (outs !== ev[i]) $display("FAIL sw_wait cyc%0d: got %h want %h", i, outs, ev[i]);
         else pass_cnt++;
         if (i < 5) step();
      end
   endtask

   task automatic test_back_to_back_branches();
      logic [22:0] ev [0:6];
      logic [5:0]  ov [0:6];
      ev = '{E_FR, E_DEC, E_BEQ, E_FR, E_DEC, E_BNE, E_FR};
      ov = '{6'h04, 6'h04, 6'h04, 6'h05, 6'h05, 6'h05, 6'h05};
      bus_if.mem_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bus_if.op = ov[i];
         #1;
         total_cnt++;
         if (outs !== ev[i]) $display("FAIL branches cyc%0d: got %h want %h", i, outs, ev[i]);
         else pass_cnt++;
         if (i < 6) step();
      end
   endtask

   task automatic test_jal_ori();
      logic [22:0] ev [0:7];
      logic [5:0]  ov [0:7];
      ev = '{E_FR, E_DEC, E_JAL, E_FR, E_DEC, E_IEX_OR, E_IWB_OR, E_FR};
      ov = '{6'h03, 6'h03, 6'h03, 6'h0D, 6'h0D, 6'h0D, 6'h0D, 6'h0D};
      bus_if.mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus_if.op = ov[i];
         #1;
         total_cnt++;
         if (outs !== ev[i]) $display("FAIL jal_ori cyc%0d: got %h want %h", i, outs, ev[i]);
         else pass_cnt++;
         if (i < 7) step();
      end
   endtask

   task automatic test_trap_and_abort();
      int trap_bad;
      bus_if.op = 6'h3F;
      bus_if.mem_ready = 1'b1;
      step();
      #1;
      total_cnt++;
      if (outs !== E_DEC) $display("FAIL trap_decode: got %h want %h", outs, E_DEC);
      else pass_cnt++;
      trap_bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         bus_if.mem_ready = (i % 2) == 0;
         #1;
         if (outs !== E_TRAP) trap_bad++;
      end
      total_cnt++;
      if (trap_bad != 0) $display("FAIL trap_hold: bad cycles %0d want 0 (last %h want %h)", trap_bad, outs, E_TRAP);
      else pass_cnt++;
      // reset clears the sticky flag, then a lw is aborted in MEMRD
      reset_n = 1'b0;
      #1;
      total_cnt++;
      if (outs !== E_ZERO) $display("FAIL trap_reset_clear: got %h want %h", outs, E_ZERO);
      else pass_cnt++;
      step();
      reset_n = 1'b1;
      bus_if.op = 6'h23;
      bus_if.mem_ready = 1'b1;
      step();
      step();
      step();
      bus_if.mem_ready = 1'b0;
      step();
      #1;
      total_cnt++;
      if (outs !== E_MRD) $display("FAIL abort_in_memrd: got %h want %h", outs, E_MRD);
      else pass_cnt++;
      reset_n = 1'b0;
      #1;
      total_cnt++;
      if (outs !== E_ZERO) $display("FAIL abort_immediate: got %h want %h", outs, E_ZERO);
      else pass_cnt++;
      step();
      reset_n = 1'b1;
      bus_if.mem_ready = 1'b1;
      #1;
      total_cnt++;
      if (outs !== E_ZERO) $display("FAIL abort_rst_state: got %h want %h", outs, E_ZERO);
      else pass_cnt++;
      step();
      #1;
      total_cnt++;
      if (outs !== E_FR) $display("FAIL abort_refetch: got %h want %h", outs, E_FR);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      reset_n = 1'b0;
      bus_if.op = 6'h00;
      bus_if.mem_ready = 1'b1;
      test_reset();
      test_rtype();
      test_lw_waits();
      test_sw_wait();
      test_back_to_back_branches();
      test_jal_ori();
      test_trap_and_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle MIPS32 datapath.
- Sequences instruction fetch, decode, execute, memory access and writeback over several cycles.
- Shares one memory port and one ALU across phases, and stalls on a memory-ready handshake.
- Takes the opcode from the instruction register and drives all datapath enables and mux selects.

Parameters:
- RA_SEL, 2'b10, reg_dst code that selects register $31 for jal.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  6  opcode from the instruction register; stable from DECODE onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- pc_write_ne  out  1  PC load if ALU not zero (bne).
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_dst  out  2  write-register select: 00=rt, 01=rd, 10=$31.
- mem_to_reg  out  2  write-data select: 00=ALUOut, 01=MDR, 10=PC.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0=PC, 1=regA.
- alu_src_b  out  2  ALU B select: 00=regB, 01=const 4, 10=ext imm, 11=sext imm<<2.
- zero_ext  out  1  immediate is zero-extended (andi/ori) instead of sign-extended.
- alu_op  out  3  000=add, 001=sub, 010=use funct, 011=and, 100=or, 101=slt.
- pc_source  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  sticky flag set on an undefined opcode.

Behaviour:
- Reset (async, reset_n=0): state=RST; every output is 0, including illegal. RST unconditionally goes to FETCH on the next clock. Reset asserted mid-instruction aborts it immediately and leaves no partial enables.
- Default: every output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0 (wait states). Goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (precomputes the branch target). Dispatch on op:
  - 0x23/0x2B -> MEMADR
  - 0x00 -> REXEC
  - 0x08/0x0C/0x0D/0x0A -> IEXEC
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - any other value -> TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add. Goes to MEMRD if op=0x23, else MEMWR.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1. Goes to FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready. instr_done=mem_ready. Goes to FETCH when mem_ready=1.
- REXEC: alu_src_a=1, alu_src_b=00, alu_op=010. Goes to RWB.
- RWB: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1. Goes to FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10. alu_op and zero_ext by op:
  - addi -> add, zero_ext=0
  - andi -> and, zero_ext=1
  - ori -> or, zero_ext=1
  - slti -> slt, zero_ext=0
  - Goes to IWB.
- IWB: reg_write=1, reg_dst=00, mem_to_reg=00; alu_op and zero_ext held as in IEXEC; instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_source=01, pc_write_cond=(op==0x04), pc_write_ne=(op==0x05), instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=RA_SEL, mem_to_reg=10, instr_done=1. Goes to FETCH. Register data is the PC before the jump, already PC+4.
- TRAP: all controls 0, illegal=1. Stays in TRAP until reset.
- Instruction latency with mem_ready=1 and no waits: R/I-type 4 cycles, lw 5, sw 4, beq/bne/j/jal 3. Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- mem_read and mem_write are never asserted in the same cycle.

Test Plan:
- Reset, then release with mem_ready=1 -> 1 cycle in RST with all outputs 0; next cycle mem_read=1, ir_write=1, pc_write=1, alu_src_b=01.
- R-type (op=0x00), mem_ready=1 -> states FETCH, DECODE, REXEC, RWB; RWB shows reg_dst=01, reg_write=1, instr_done=1; next FETCH on cycle 5.
- lw (op=0x23) with mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD -> 10 cycles total; ir_write pulses only on the ready cycle; MEMWB shows mem_to_reg=01.
- beq (0x04) then bne (0x05) -> BRANCH state shows pc_write_cond=1/pc_write_ne=0, then 0/1; alu_op=001, pc_source=01; 3 cycles each.
- jal (0x03) -> JAL shows reg_dst=10, mem_to_reg=10, reg_write=1, pc_write=1, pc_source=10; ori (0x0D) -> zero_ext=1, alu_op=100.
- op=0x3F -> TRAP with illegal=1 held for 20 cycles and all enables 0. Then assert reset_n=0 in MEMRD of a later lw -> outputs 0 immediately; illegal cleared.
